wishbone_ram_slave: RTL
=======================

WISHBONE_RAM_SLAVE -- requirements
Module: wishbone_ram_slave

Interface
REQ-001 The block SHALL accept the following parameters:
- ADDR_WIDTH, default 32, byte address width.
- DATA_WIDTH, default 32, data width; a multiple of 8.
- TAG_WIDTH, default 3, tag width.
- DEPTH, default 256, number of DATA_WIDTH-bit words stored.
- WAIT_STATES, default 1, extra cycles inserted before each response (0..15).
- BASE_ADDR, default 0, byte address of word 0.

REQ-002 The block SHALL have the following ports, in this order:
- sys_clk  in  1  single clock; all state updates on its rising edge.
- sys_rst  in  1  asynchronous, active-low reset.
- wb_cyc  in  1  bus cycle valid.
- wb_stb  in  1  request strobe.
- wb_we  in  1  1 = write, 0 = read.
- wb_tag  in  TAG_WIDTH  request tag; captured but functionally ignored.
- wb_sel  in  DATA_WIDTH/8  byte enables.
- wb_adr  in  ADDR_WIDTH  byte address.
- wb_mosi  in  DATA_WIDTH  write data.
- wb_miso  out  DATA_WIDTH  read data.
- wb_ack  out  1  successful termination.
- wb_err  out  1  error termination.

REQ-003 All outputs SHALL be registered; no combinational path from input to output.

Function
REQ-004 The block SHALL implement states IDLE, WAIT and RESP; wb_ack and wb_err SHALL only ever be high in RESP, and never both at once.

REQ-005 In IDLE, when wb_cyc & wb_stb is sampled high, the block SHALL latch we, sel, adr, mosi and tag:
- WAIT_STATES = 0: go to RESP.
- Otherwise: load a counter with WAIT_STATES and go to WAIT.

REQ-006 In WAIT, the block SHALL decrement the counter each cycle and go to RESP on the edge where the counter is 1.
- Response latency is therefore WAIT_STATES+1 edges after the accepting edge.

REQ-007 If wb_cyc is sampled low in WAIT, the block SHALL abort: return to IDLE, perform no write, assert neither ack nor err.

REQ-008 RESP SHALL last exactly one cycle, then return to IDLE. wb_cyc/wb_stb sampled on the edge leaving RESP SHALL be ignored.
- Minimum spacing: one idle cycle between a termination and the next acceptance.

REQ-009 The latched request SHALL be in error if any of the following holds:
- adr < BASE_ADDR;
- adr is not aligned to DATA_WIDTH/8 bytes;
- (adr - BASE_ADDR)/(DATA_WIDTH/8) >= DEPTH.

REQ-010 On entering RESP, an error request SHALL set wb_err=1, wb_ack=0, wb_miso=0, with no memory change.

REQ-011 On entering RESP, a valid write SHALL set wb_ack=1 and wb_miso=0, and SHALL update only the bytes whose sel bit is 1 on that same edge.
- sel = 0 is a valid no-op write.

REQ-012 On entering RESP, a valid read SHALL set wb_ack=1 and drive the full stored word on wb_miso, independent of sel.

REQ-013 Outside RESP, wb_miso SHALL be 0.

REQ-014 A read issued after a write to the same word SHALL return the written data; there is no read-after-write hazard.

REQ-015 The word index SHALL be computed with ADDR_WIDTH-bit unsigned subtraction, with no wrap into the valid range.

Reset
REQ-016 sys_rst low SHALL immediately force state=IDLE, counter=0, wb_ack=0, wb_err=0, wb_miso=0, regardless of the clock.

REQ-017 Reset asserted mid-transaction SHALL abandon it, with no write and no termination.

REQ-018 Memory contents SHALL NOT be cleared by reset.

REQ-019 After sys_rst rises, the first request SHALL be acceptable on the next rising edge.

Verification
REQ-020 The bench SHALL cover these directed scenarios (defaults, WAIT_STATES=1):
- Write then read: write 0xDEADBEEF, sel=0xF to 0x10, then read 0x10 -> each ack high exactly one cycle, 2 edges after acceptance; read wb_miso=0xDEADBEEF.
- Byte enables: after the above, write 0x11223344 sel=0x5 to 0x10, then read -> 0xDE22BE44.
- Errors, each -> wb_err=1 for one cycle, wb_ack=0, wb_miso=0, memory unchanged:
  - read at adr 0x400 (index 256);
  - write at adr 0x13 (misaligned).
- Abort: drop wb_cyc in WAIT during a write of 0xCAFEF00D to 0x20 -> no ack/err; a later read of 0x20 returns the prior value.
- Back-to-back: master holds stb until ack and reasserts it the cycle after ack falls -> exactly one termination per request, none duplicated.
- Reset mid-WAIT and zero wait states:
  - Pull sys_rst low mid-WAIT -> outputs 0 without a clock edge; no termination after release.
  - With WAIT_STATES=0 -> ack one edge after acceptance.

Source files
------------

// File: rtl/wishbone_ram_slave.sv
// Wishbone word RAM slave with byte enables and configurable wait states.
// Responses are fully registered; bad addresses terminate with err.
module wishbone_ram_slave #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TAG_WIDTH = 3,
  parameter int unsigned DEPTH = 256,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic                    wb_cyc,
  input  logic                    wb_stb,
  input  logic                    wb_we,
  input  logic [TAG_WIDTH-1:0]    wb_tag,
  input  logic [DATA_WIDTH/8-1:0] wb_sel,
  input  logic [ADDR_WIDTH-1:0]   wb_adr,
  input  logic [DATA_WIDTH-1:0]   wb_mosi,
  output logic [DATA_WIDTH-1:0]   wb_miso,
  output logic                    wb_ack,
  output logic                    wb_err
);

  localparam int unsigned NB = DATA_WIDTH / 8;
  localparam int unsigned LB = $clog2(NB);
  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic we_q, we_d;
  logic [NB-1:0] sel_q, sel_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [DATA_WIDTH-1:0] mosi_q, mosi_d;
  logic [TAG_WIDTH-1:0] tag_q, tag_d;
  logic ack_q, ack_d;
  logic err_q, err_d;
  logic [DATA_WIDTH-1:0] miso_q, miso_d;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  req_we;
  logic [NB-1:0]         req_sel;
  logic [ADDR_WIDTH-1:0] req_adr;
  logic [DATA_WIDTH-1:0] req_mosi;
  logic [ADDR_WIDTH-1:0] req_off;
  logic [ADDR_WIDTH-1:0] req_word;
  logic [IW-1:0]         req_idx;
  logic                  req_bad;
  logic                  go_resp;
  logic                  mem_we;
  logic                  unused_tag;

  assign unused_tag = ^tag_q;

  // With zero wait states the response is built from the live bus inputs
  always_comb begin
    if (state_q == IDLE) begin
      req_we   = wb_we;
      req_sel  = wb_sel;
      req_adr  = wb_adr;
      req_mosi = wb_mosi;
    end else begin
      req_we   = we_q;
      req_sel  = sel_q;
      req_adr  = adr_q;
      req_mosi = mosi_q;
    end
  end

  assign req_off  = req_adr - BASE_ADDR;
  assign req_word = req_off >> LB;
  assign req_idx  = req_word[IW-1:0];
  assign req_bad  = (req_adr < BASE_ADDR)
                 || ((req_adr & ADDR_WIDTH'(NB - 1)) != '0)
                 || (req_word >= ADDR_WIDTH'(DEPTH));

  // Next-state, request latch and registered response values
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    sel_d   = sel_q;
    adr_d   = adr_q;
    mosi_d  = mosi_q;
    tag_d   = tag_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    miso_d  = '0;
    go_resp = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (wb_cyc && wb_stb) begin
          we_d   = wb_we;
          sel_d  = wb_sel;
          adr_d  = wb_adr;
          mosi_d = wb_mosi;
          tag_d  = wb_tag;
          if (WAIT_STATES == 0) begin
            state_d = RESP;
            go_resp = 1'b1;
          end else begin
            cnt_d   = 4'(WAIT_STATES);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (!wb_cyc) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = RESP;
            go_resp = 1'b1;
          end
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (go_resp) begin
      if (req_bad) begin
        err_d = 1'b1;
      end else begin
        ack_d = 1'b1;
        if (!req_we) miso_d = mem_q[req_idx];
      end
    end
  end

  assign mem_we = go_resp && !req_bad && req_we && sys_rst;

  // Control and output registers, cleared asynchronously
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      adr_q   <= '0;
      mosi_q  <= '0;
      tag_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      miso_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      adr_q   <= adr_d;
      mosi_q  <= mosi_d;
      tag_q   <= tag_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      miso_q  <= miso_d;
    end
  end

  // Storage array keeps its contents across reset
  always_ff @(posedge sys_clk) begin
    if (mem_we) begin
      for (int b = 0; b < int'(NB); b++) begin
        if (req_sel[b]) mem_q[req_idx][8*b +: 8] <= req_mosi[8*b +: 8];
      end
    end
  end

  assign wb_ack  = ack_q;
  assign wb_err  = err_q;
  assign wb_miso = miso_q;

endmodule
